// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 16;
  localparam int CNT_W     = $clog2(DEF_WIDTH);
  localparam logic [DEF_WIDTH-1:0] DZ_QUOT = {DEF_WIDTH{1'b1}};

endpackage

// File: rtl/div_sub_stage.sv
// One restoring-division step: trial subtract of the divisor from the shifted
// partial remainder, done as an add of the inverted divisor with carry-in 1.
module div_sub_stage #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             qbit_o
);

  logic [WIDTH:0] x_s;
  logic [WIDTH:0] y_s;
  logic [WIDTH:0] g_s;
  logic [WIDTH:0] p_s;
  logic [WIDTH:0] c_s;
  logic [WIDTH:0] t_s;

  assign x_s = {rem_i, bit_i};
  assign y_s = ~{1'b0, div_i};
  assign g_s = x_s & y_s;
  assign p_s = x_s ^ y_s;

  // Carry chain from generate/propagate terms, carry-in of one completes the negation.
  always_comb begin
    c_s[0] = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      c_s[i+1] = g_s[i] | (p_s[i] & c_s[i]);
    end
  end

  assign t_s    = p_s ^ c_s;
  assign qbit_o = ~t_s[WIDTH];
  // A borrow means the divisor did not fit: keep the shifted remainder.
  assign rem_o  = qbit_o ? t_s[WIDTH-1:0] : x_s[WIDTH-1:0];

endmodule

// File: rtl/div16_seq.sv
// Multi-cycle unsigned restoring divider with start/busy/done handshake.
// One quotient bit per cycle; results and dz are held until the next completion.
module div16_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             dz
);

  localparam int CW = ($clog2(WIDTH) > CNT_W) ? $clog2(WIDTH) : CNT_W;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] qsh_q, qsh_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remo_q, remo_d;
  logic             dz_q, dz_d;

  logic [WIDTH-1:0] step_rem_s;
  logic             step_qbit_s;

  div_sub_stage #(.WIDTH(WIDTH)) u_stage (
    .rem_i  (rem_q),
    .bit_i  (qsh_q[WIDTH-1]),
    .div_i  (div_q),
    .rem_o  (step_rem_s),
    .qbit_o (step_qbit_s)
  );

  // Next-state, datapath and output-register update.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    qsh_d   = qsh_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    quot_d  = quot_q;
    remo_d  = remo_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (b != {WIDTH{1'b0}}) begin
            rem_d   = {WIDTH{1'b0}};
            qsh_d   = a;
            div_d   = b;
            cnt_d   = CW'(WIDTH - 1);
            state_d = CALC;
          end else begin
            quot_d  = {WIDTH{DZ_QUOT[0]}};
            remo_d  = a;
            dz_d    = 1'b1;
            done_d  = 1'b1;
            state_d = FIN;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        rem_d = step_rem_s;
        qsh_d = {qsh_q[WIDTH-2:0], step_qbit_s};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == {CW{1'b0}}) begin
          // Results become visible together with done in FIN.
          quot_d  = {qsh_q[WIDTH-2:0], step_qbit_s};
          remo_d  = step_rem_s;
          dz_d    = 1'b0;
          done_d  = 1'b1;
          state_d = FIN;
        end else begin
          state_d = CALC;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and register update; reset aborts any division in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= {WIDTH{1'b0}};
      qsh_q   <= {WIDTH{1'b0}};
      div_q   <= {WIDTH{1'b0}};
      cnt_q   <= {CW{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= {WIDTH{1'b0}};
      remo_q  <= {WIDTH{1'b0}};
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      qsh_q   <= qsh_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      dz_q    <= dz_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quot_q;
  assign remainder = remo_q;
  assign dz        = dz_q;

endmodule

// File: tb/tb_div16_seq.sv
// Self-checking bench for div16_seq: directed cases plus a random sweep
// against a plain / and % reference.
module tb_div16_seq;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         dz;

  int n_assert;
  int n_fail;

  div16_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dz        (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Expected latency counted in falling edges after the accepting rising edge.
  function automatic int exp_lat(input logic [W-1:0] bv);
    return (bv == 16'd0) ? 1 : W + 1;
  endfunction

  // Waits for done after the caller has just seen the accepting edge, at a negedge.
  task automatic wait_done(output int lat);
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv, input int lat);
    logic [W-1:0] eq;
    logic [W-1:0] er;
    if (bv == 16'd0) begin
      eq = 16'hFFFF;
      er = av;
    end else begin
      eq = av / bv;
      er = av % bv;
    end
    check({tag, ".lat"}, 32'(lat), 32'(exp_lat(bv)));
    check({tag, ".quot"}, 32'(quotient), 32'(eq));
    check({tag, ".rem"}, 32'(remainder), 32'(er));
    check({tag, ".dz"}, 32'(dz), 32'(bv == 16'd0));
    @(negedge clk);
    check({tag, ".done_pulse"}, 32'(done), 32'd0);
  endtask

  // Runs one division from IDLE; called at a negedge.
  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv);
    int lat;
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = $urandom();
    b = $urandom();
    check({tag, ".busy"}, 32'(busy), 32'd1);
    wait_done(lat);
    check_result(tag, av, bv, lat);
  endtask

  initial begin
    int lat;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    n_assert = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    start = 1'b0;
    a = 16'd0;
    b = 16'd0;
    repeat (3) @(negedge clk);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.quot", 32'(quotient), 32'd0);
    check("rst.rem", 32'(remainder), 32'd0);
    check("rst.dz", 32'(dz), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("t1_100_7", 16'd100, 16'd7);
    run_op("t2_ffff_1", 16'hFFFF, 16'd1);
    run_op("t2_ffff_ffff", 16'hFFFF, 16'hFFFF);
    run_op("t3_3_10", 16'd3, 16'd10);
    run_op("t3_0_5", 16'd0, 16'd5);
    run_op("t4_5_0", 16'd5, 16'd0);
    run_op("t4_9_3", 16'd9, 16'd3);

    // Start while busy must not disturb the running division or the held results.
    a = 16'd1000;
    b = 16'd9;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    a = 16'd1;
    b = 16'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t5.held_quot", 32'(quotient), 32'd3);
    check("t5.held_rem", 32'(remainder), 32'd0);
    check("t5.busy", 32'(busy), 32'd1);
    lat = 5;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check_result("t5_1000_9", 16'd1000, 16'd9, lat);

    // Asynchronous reset in the middle of a division.
    a = 16'd1234;
    b = 16'd7;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6.rst_busy", 32'(busy), 32'd0);
    check("t6.rst_done", 32'(done), 32'd0);
    check("t6.rst_quot", 32'(quotient), 32'd0);
    check("t6.rst_rem", 32'(remainder), 32'd0);
    check("t6.rst_dz", 32'(dz), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6.idle_done", 32'(done), 32'd0);
    run_op("t6_50_6", 16'd50, 16'd6);

    // Random sweep biased toward small divisors and occasional zero.
    for (int i = 0; i < 2000; i++) begin
      ra = $urandom();
      case ($urandom_range(3, 0))
        0:       rb = 16'($urandom_range(15, 0));
        1:       rb = 16'($urandom_range(255, 1));
        2:       rb = ra >> $urandom_range(15, 0);
        default: rb = $urandom();
      endcase
      run_op("rand", ra, rb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
